seq_left_logic_shifter: RTL and testbench
=========================================

// Module: seq_left_logic_shifter
// PURPOSE
//   Multi-cycle logical LEFT shifter for the ALU datapath; the opposite direction of the
//   combinational right logic shifter. Shifts operand a left by one bit per clock under a
//   start/busy/done handshake. Zeros are filled at the LSB.
//   Serves the ALU's slow-path shift unit, where area matters more than latency.
// PARAMETERS
//   N   4                  operand/result width in bits (N >= 2)
//   SW  $clog2(N)+1        shift-amount width; localparam, derived from N, not overridable
// PORTS
//   clk    in   1    single clock, rising edge
//   rst    in   1    synchronous reset, active-high
//   a      in   N    operand, sampled only on an accepted start
//   shift  in   SW   shift amount, sampled only on an accepted start
//   start  in   1    request; accepted only while busy==0
//   busy   out  1    1 while an operation is in progress (SHIFT state)
//   done   out  1    one-cycle pulse: y holds the final result
//   y      out  N    result register; holds its value until the next accepted start
// BEHAVIOUR
//   - Reset (sync, active-high, highest priority): state=IDLE, y=0, busy=0, done=0,
//     count=0. Reset mid-operation aborts the operation with no done pulse.
//   - FSM states: IDLE, SHIFT, DONE.
//     IDLE : start=1 -> y<=a; count<=min(shift,N); state<=SHIFT, or DONE if shift==0.
//     SHIFT: y<={y[N-2:0],1'b0}; count<=count-1; when count==1 -> DONE.
//     DONE : done=1 for exactly this cycle; busy=0; go to IDLE.
//            start=1 in DONE is accepted as if in IDLE (back-to-back issue).
//   - busy=1 only in SHIFT. start while busy is ignored; a/shift are not re-sampled.
//   - Latency: start accepted at edge k -> done high in the cycle after edge
//     k+max(min(shift,N),1). Worst case is N+1 cycles from start to done.
//   - shift>=N: count saturates at N, so the result is all zeros after N cycles.
//   - y is only updated by the shift steps; it never shows stale a bits beyond the
//     sampled operand.
//   - Arithmetic: purely logical, no sign extension; width-exact, all bits shifted
//     out at the MSB are discarded.
// CONFIGURATION
//   `define LEFT_SHIFT_CARRY_EN
//     Defined: adds output port `carry  out  1`. It holds the last bit shifted out of
//       y[N-1]. Reset to 0, cleared on an accepted start, updated on every SHIFT step,
//       valid with done. shift==0 gives carry=0.
//       Example: N=4, a=4'b1011, shift=1 -> y=4'b0110, carry=1.
//     Undefined: the port and its register do not exist; all other behaviour is identical.
// TESTING (N=4)
//   1. rst=1 for 2 clocks -> y=0000, busy=0, done=0; carry=0 if enabled.
//   2. a=0001, shift=1, start pulse -> busy for 1 cycle, done pulse, y=0010.
//      a=1111, shift=2 -> y=1100 after 2 busy cycles; carry=1 if enabled.
//   3. a=1011, shift=0 -> no busy cycle, done next cycle, y=1011.
//      a=0110, shift=7 -> 4 busy cycles, y=0000.
//   4. a=0101, shift=3; re-assert start with a=1111 while busy -> ignored, y=1000.
//      Start a=0011, shift=1 in the DONE cycle -> accepted, y=0110.
//   5. a=1001, shift=3; rst=1 on the 2nd busy cycle -> next cycle y=0000, busy=0,
//      no done pulse. Then a=1001, shift=1 -> y=0010.
//   6. Exhaustive sweep: all a in 0..15 x shift in 0..7 vs reference (a<<shift)&4'hF.
//      Check that done fires exactly once per op and busy cycles == min(shift,4).

Source files
------------

// File: rtl/seq_left_logic_shifter.sv
// Serial logical left shifter, one bit per clock; done arrives min(shift,N) cycles after accept (next cycle if shift==0).
// start is ignored while busy and accepted in IDLE or DONE; `LEFT_SHIFT_CARRY_EN adds the carry output.
module seq_left_logic_shifter #(
   parameter  int N  = 4,
   localparam int SW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] shift,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  y
`ifdef LEFT_SHIFT_CARRY_EN
   ,
   output logic          carry
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [SW-1:0] count;
   logic [SW-1:0] amt;
   logic          accept;

   // Amounts of N or more all produce zero, so the step count saturates at N.
   assign amt    = (shift >= SW'(N)) ? SW'(N) : shift;
   assign accept = start && (state != SHIFT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (shift == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (count == SW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = (shift == '0) ? DONE : SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y     <= '0;
         count <= '0;
      end else if (accept) begin
         y     <= a;
         count <= amt;
      end else if (state == SHIFT) begin
         y     <= {y[N-2:0], 1'b0};
         count <= count - SW'(1);
      end
   end

`ifdef LEFT_SHIFT_CARRY_EN
   // Captures the bit leaving y[N-1] on each step; the last one stands at done.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry <= 1'b0;
      end else if (accept) begin
         carry <= 1'b0;
      end else if (state == SHIFT) begin
         carry <= y[N-1];
      end
   end
`endif

endmodule

// File: tb/tb_seq_left_logic_shifter.sv
// Randomized bench for seq_left_logic_shifter against an arithmetic reference (a<<shift, masked).
module tb_seq_left_logic_shifter;

   localparam int N  = 4;
   localparam int SW = $clog2(N) + 1;

   logic          clk;
   logic          rst;
   logic [N-1:0]  a;
   logic [SW-1:0] shift;
   logic          start;
   logic          busy;
   logic          done;
   logic [N-1:0]  y;
   logic          carry;

   int checks = 0;
   int errors = 0;

   seq_left_logic_shifter #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .a     (a),
      .shift (shift),
      .start (start),
      .busy  (busy),
      .done  (done),
      .y     (y)
`ifdef LEFT_SHIFT_CARRY_EN
      ,
      .carry (carry)
`endif
   );

`ifndef LEFT_SHIFT_CARRY_EN
   assign carry = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int eff_amt(input int sv);
      return (sv > N) ? N : sv;
   endfunction

   function automatic int ref_y(input int av, input int sv);
      return (av << eff_amt(sv)) & ((1 << N) - 1);
   endfunction

   function automatic int ref_carry(input int av, input int sv);
      return ((av << eff_amt(sv)) >> N) & 1;
   endfunction

   // Present a request for the coming edge; caller is at a negedge where start is accepted.
   task automatic launch(input logic [N-1:0] av, input logic [SW-1:0] sv);
      a     = av;
      shift = sv;
      start = 1'b1;
   endtask

   // Follow an accepted op to its done pulse and compare against the reference.
   task automatic finish_op(input string tag, input int av, input int sv,
                            input bit noise, input bit chain);
      int cyc;
      int busy_cnt;
      cyc      = 0;
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b0;
      while (done !== 1'b1 && cyc < 4 * N + 8) begin
         if (busy === 1'b1) begin
            busy_cnt++;
            if (noise) begin
               start = 1'b1;
               a     = N'($urandom);
               shift = SW'($urandom);
            end
         end
         @(negedge clk);
         start = 1'b0;
         cyc++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'(1));
      check({tag, "_y"}, 32'(y), 32'(ref_y(av, sv)));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(eff_amt(sv)));
      check({tag, "_latency"}, 32'(cyc), 32'(eff_amt(sv)));
      check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
`ifdef LEFT_SHIFT_CARRY_EN
      check({tag, "_carry"}, 32'(carry), 32'(ref_carry(av, sv)));
`endif
      if (!chain) begin
         @(negedge clk);
         check({tag, "_done_once"}, 32'(done), 32'(0));
         check({tag, "_y_hold"}, 32'(y), 32'(ref_y(av, sv)));
      end
   endtask

   initial begin
      logic [N-1:0]  av;
      logic [SW-1:0] sv;
      bit            ch;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      shift = '0;
      repeat (2) @(negedge clk);
      check("reset_y", 32'(y), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      check("reset_done", 32'(done), 32'(0));
      check("reset_carry", 32'(carry), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      launch(4'b0001, 3'd1); finish_op("t2a", 1, 1, 0, 0);
      launch(4'b1111, 3'd2); finish_op("t2b", 15, 2, 0, 0);
      launch(4'b1011, 3'd1); finish_op("carry_ex", 11, 1, 0, 0);
      launch(4'b1011, 3'd0); finish_op("t3a", 11, 0, 0, 0);
      launch(4'b0110, 3'd7); finish_op("t3b", 6, 7, 0, 0);

      // Start re-asserted while busy must be ignored; start in DONE is accepted.
      launch(4'b0101, 3'd3); finish_op("t4a", 5, 3, 1, 1);
      launch(4'b0011, 3'd1); finish_op("t4b", 3, 1, 0, 0);

      // Reset on the second busy cycle aborts without a done pulse.
      launch(4'b1001, 3'd3);
      @(negedge clk); start = 1'b0;
      @(negedge clk); rst = 1'b1;
      check("t5_busy_before_rst", 32'(busy), 32'(1));
      @(negedge clk); rst = 1'b0;
      check("t5_y", 32'(y), 32'(0));
      check("t5_busy", 32'(busy), 32'(0));
      check("t5_done", 32'(done), 32'(0));
      check("t5_carry", 32'(carry), 32'(0));
      @(negedge clk);
      check("t5_no_done", 32'(done), 32'(0));
      launch(4'b1001, 3'd1); finish_op("t5b", 9, 1, 0, 0);

      for (int ai = 0; ai < (1 << N); ai++) begin
         for (int si = 0; si < (1 << SW); si++) begin
            launch(N'(ai), SW'(si));
            finish_op("sweep", ai, si, 1'($urandom_range(0, 1)), 0);
         end
      end

      av = N'($urandom);
      sv = SW'($urandom);
      launch(av, sv);
      repeat (60) begin
         ch = 1'($urandom_range(0, 1));
         finish_op("rnd", int'(av), int'(sv), 1'($urandom_range(0, 1)), ch);
         av = N'($urandom);
         sv = SW'($urandom);
         launch(av, sv);
      end
      finish_op("rnd_last", int'(av), int'(sv), 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
